// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Two-requester arbiter in front of a single-port RAM with registered read
// data. After reset the block first clears every RAM word to zero (INIT) and
// then arbitrates accesses from requesters 0 and 1 (RUN).
//
// Handshake (same rule for both requesters):
//   reqN is "valid", gntN is "ready". A transfer happens in a cycle where
//   reqN && gntN. gntN is combinational from reqN in the same cycle. A
//   requester holds reqN/wrN/addrN/wdataN stable until it sees gntN; after the
//   transfer it may drop reqN or present a new request immediately. The
//   requester never waits on gntN before raising reqN. Read data returns
//   one cycle after a read transfer, flagged by rvalidN.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   req0/1, wr0/1       request, access type (1 = write, 0 = read)
//   addr0/1, wdata0/1   request address and write data
//   gnt0/1              request accepted this cycle
//   rvalid0/1           read data on rdata belongs to that requester
//   rdata               shared read-data bus (follows ram_rdata)
//   busy                high while the RAM is being cleared (and in reset)
//   ram_en, ram_wr      RAM enable and write strobe
//   ram_addr, ram_wdata RAM address and write data
//   ram_rdata           RAM registered read data (valid one cycle after read)
//   dbg_run             init-state register: 0 = INIT, 1 = RUN
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dbg_run
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // 1 = requester 1 was granted most recently, 0 = requester 0.
  logic              last_q, last_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic              pick1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      // Pretend requester 1 won last so requester 0 takes the first tie.
      last_q  <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  // Requester 1 wins if it is the only one asking, or on a tie when
  // requester 0 had the previous grant.
  assign pick1 = req1 & (~req0 | ~last_q);

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    rv0_d     = 1'b0;
    rv1_d     = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    busy      = 1'b1;
    ram_en    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    // While rst is high all outputs stay at their idle defaults; the
    // register block above takes care of the state.
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          // Clear one word per cycle; requests are not looked at.
          ram_en   = 1'b1;
          ram_wr   = 1'b1;
          ram_addr = cnt_q;
          if (cnt_q == CNT_MAX) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          busy = 1'b0;
          if (pick1) begin
            gnt1      = 1'b1;
            ram_en    = 1'b1;
            ram_wr    = wr1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
            rv1_d     = ~wr1;
            last_d    = 1'b1;
          end else if (req0) begin
            gnt0      = 1'b1;
            ram_en    = 1'b1;
            ram_wr    = wr0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
            rv0_d     = ~wr0;
            last_d    = 1'b0;
          end
        end

        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  // A reset arriving right after a read grant must swallow the pending
  // rvalid in that same cycle, before the register has been cleared.
  assign rvalid0 = rv0_q & ~rst;
  assign rvalid1 = rv1_q & ~rst;
  assign rdata   = ram_rdata;
  assign dbg_run = (state_q == ST_RUN);

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter with a behavioural RAM (registered read,
// write-then-read returns new data). The RAM is filled with all-ones while
// rst is high so the INIT clearing is visible in later reads.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              req0, req1, wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DATA_W-1:0] rdata;
  logic              ram_en, ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              dbg_run;

  int checks   = 0;
  int failures = 0;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .wr0       (wr0),
    .wr1       (wr1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .busy      (busy),
    .ram_en    (ram_en),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .dbg_run   (dbg_run)
  );

  // ---------------------------------------------------------------------------
  // Behavioural RAM
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
    end else if (ram_en) begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic r1, input logic w1,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int exp_g;
    rst = 1'b1;
    set_req(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd0);

    // Reset held: everything idle, busy high.
    to_check();
    check("rst_gnt0",   gnt0,    0);
    check("rst_gnt1",   gnt1,    0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_ram_en", ram_en,  0);
    check("rst_ram_wr", ram_wr,  0);
    check("rst_busy",   busy,    1);
    check("rst_dbg",    dbg_run, 0);

    to_drive();
    to_drive();
    rst = 1'b0;

    // INIT: 16 clearing writes, both requests held and ignored.
    for (int i = 0; i < DEPTH; i++) begin
      to_check();
      check($sformatf("init_busy_%0d", i),  busy,      1);
      check($sformatf("init_gnt_%0d", i),   {gnt1, gnt0}, 0);
      check($sformatf("init_en_%0d", i),    {ram_en, ram_wr}, 2'b11);
      check($sformatf("init_addr_%0d", i),  ram_addr,  i);
      check($sformatf("init_wdata_%0d", i), ram_wdata, 0);
      to_drive();
    end

    // Cycle 17: first tie goes to requester 0.
    to_check();
    check("c17_gnt0", gnt0, 1);
    check("c17_gnt1", gnt1, 0);
    check("c17_busy", busy, 0);
    check("c17_dbg",  dbg_run, 1);
    check("c17_ram",  {ram_en, ram_wr, ram_addr}, {1'b1, 1'b0, 4'd0});
    to_drive();

    // Cycles 18..23: round-robin 1,0,1,0,1,0 with rvalid one cycle later.
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 1 : 0;
      to_check();
      check($sformatf("rr_gnt1_%0d", k), gnt1, (exp_g == 1) ? 1 : 0);
      check($sformatf("rr_gnt0_%0d", k), gnt0, (exp_g == 0) ? 1 : 0);
      check($sformatf("rr_rv1_%0d", k), rvalid1, (exp_g == 0) ? 1 : 0);
      check($sformatf("rr_rv0_%0d", k), rvalid0, (exp_g == 1) ? 1 : 0);
      check($sformatf("rr_rdata_%0d", k), rdata, 0);
      to_drive();
    end

    // Idle: no grant, rvalid0 from last round-robin grant, cleared data.
    set_req(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    to_check();
    check("idle_gnt",   {gnt1, gnt0}, 0);
    check("idle_ram",   {ram_en, ram_wr}, 0);
    check("idle_rv0",   rvalid0, 1);
    check("idle_rv1",   rvalid1, 0);
    check("idle_rdata", rdata,   0);
    to_drive();

    // Write 0xA to address 5.
    set_req(1'b1, 1'b1, 4'd5, 4'hA, 1'b0, 1'b0, 4'd0, 4'd0);
    to_check();
    check("wr5_gnt0",  gnt0, 1);
    check("wr5_ram",   {ram_en, ram_wr, ram_addr, ram_wdata}, {1'b1, 1'b1, 4'd5, 4'hA});
    check("wr5_rv",    {rvalid1, rvalid0}, 0);
    to_drive();

    // Read address 5 back-to-back.
    set_req(1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    to_check();
    check("rd5_gnt0",  gnt0, 1);
    check("rd5_ram",   {ram_en, ram_wr, ram_addr}, {1'b1, 1'b0, 4'd5});
    check("rd5_no_rv", {rvalid1, rvalid0}, 0);
    to_drive();

    set_req(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    to_check();
    check("rd5_rv0",   rvalid0, 1);
    check("rd5_rv1",   rvalid1, 0);
    check("rd5_rdata", rdata,   4'hA);
    to_drive();

    // Single read by requester 1 (addr 9, never written) so last grant = 1.
    set_req(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd9, 4'd0);
    to_check();
    check("rd9_gnt", {gnt1, gnt0}, 2'b10);
    check("rd9_addr", ram_addr, 9);
    to_drive();

    // Tie: req0 write addr 3 = 7, req1 read addr 3. Write goes first.
    set_req(1'b1, 1'b1, 4'd3, 4'h7, 1'b1, 1'b0, 4'd3, 4'd0);
    to_check();
    check("tie_gnt",   {gnt1, gnt0}, 2'b01);
    check("tie_ram",   {ram_en, ram_wr, ram_addr, ram_wdata}, {1'b1, 1'b1, 4'd3, 4'h7});
    check("rd9_rv1",   rvalid1, 1);
    check("rd9_rdata", rdata,   0);
    to_drive();

    req0 = 1'b0;
    to_check();
    check("tie2_gnt", {gnt1, gnt0}, 2'b10);
    check("tie2_ram", {ram_en, ram_wr, ram_addr}, {1'b1, 1'b0, 4'd3});
    check("tie2_rv",  {rvalid1, rvalid0}, 0);
    to_drive();

    // Read grant to requester 0, followed immediately by reset.
    set_req(1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    to_check();
    check("pre_rst_gnt0",  gnt0,    1);
    check("tie_rv1",       rvalid1, 1);
    check("tie_rdata",     rdata,   4'h7);
    to_drive();

    rst = 1'b1;
    req0 = 1'b0;
    to_check();
    check("mid_rst_rv0",  rvalid0, 0);
    check("mid_rst_busy", busy,    1);
    check("mid_rst_gnt",  {gnt1, gnt0}, 0);
    check("mid_rst_ram",  {ram_en, ram_wr}, 0);
    to_drive();

    rst = 1'b0;
    set_req(1'b1, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 4'd6, 4'd0);
    to_check();
    check("reinit_busy", busy, 1);
    check("reinit_ram",  {ram_en, ram_wr, ram_addr, ram_wdata}, {1'b1, 1'b1, 4'd0, 4'd0});
    check("reinit_gnt",  {gnt1, gnt0}, 0);
    check("reinit_rv",   {rvalid1, rvalid0}, 0);
    check("reinit_dbg",  dbg_run, 0);
    to_drive();

    to_check();
    check("reinit_addr1", ram_addr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
